// File: rtl/ring_tdm_input_queue.sv
// Two-domain TDM input queue for one ring-router port.
// Dequeue timing depends only on the slot counter and the active domain's FIFO.
module ring_tdm_input_queue #(
   parameter int p_msg_nbits   = 32,
   parameter int p_num_entries = 2,
   parameter int p_slot_cycles = 4,
   parameter int p_dead_cycles = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_val,
   output logic                             in_rdy,
   input  logic [p_msg_nbits-1:0]           in_msg,
   input  logic                             in_domain,
   output logic                             out_val,
   input  logic                             out_rdy,
   output logic [p_msg_nbits-1:0]           out_msg,
   output logic                             slot_domain,
   output logic [$clog2(p_slot_cycles)-1:0] slot_cnt
);

   localparam int c_pw   = $clog2(p_num_entries);
   localparam int c_cw   = c_pw + 1;
   localparam int c_sw   = $clog2(p_slot_cycles);
   localparam int c_live = p_slot_cycles - p_dead_cycles;

   if (p_msg_nbits < 1 ||
       p_num_entries < 2 || p_num_entries > 8 ||
       (p_num_entries & (p_num_entries - 1)) != 0 ||
       p_slot_cycles < 2 ||
       p_dead_cycles < 0 || p_dead_cycles >= p_slot_cycles) begin : g_bad_param
      $error("ring_tdm_input_queue: illegal parameter values");
   end

   logic [c_sw-1:0]        r_slot_cnt;
   logic                   r_slot_dom;
   logic [c_pw-1:0]        r_head [2];
   logic [c_pw-1:0]        r_tail [2];
   logic [c_cw-1:0]        r_cnt  [2];
   logic [p_msg_nbits-1:0] r_mem  [2][p_num_entries];

   logic       w_in_full;
   logic       w_enq;
   logic       w_live;
   logic       w_act_nempty;
   logic       w_out_val;
   logic       w_deq;
   logic [1:0] w_enq_d;
   logic [1:0] w_deq_d;

   // Full is judged from the registered count; a same-cycle pop does not help
   always_comb begin
      w_in_full    = (r_cnt[in_domain] == c_cw'(p_num_entries));
      w_enq        = in_val && !w_in_full;
      w_live       = ({1'b0, r_slot_cnt} < (c_sw + 1)'(c_live));
      w_act_nempty = (r_cnt[r_slot_dom] != '0);
      w_out_val    = w_act_nempty && w_live;
      w_deq        = w_out_val && out_rdy;
      w_enq_d      = 2'b00;
      w_deq_d      = 2'b00;
      w_enq_d[in_domain]  = w_enq;
      w_deq_d[r_slot_dom] = w_deq;
   end

   assign in_rdy      = !w_in_full;
   assign out_val     = w_out_val;
   assign out_msg     = w_out_val ?
                        r_mem[r_slot_dom][r_head[r_slot_dom]] :
                        '0;
   assign slot_domain = r_slot_dom;
   assign slot_cnt    = r_slot_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_slot_cnt <= '0;
         r_slot_dom <= 1'b0;
      end else if (r_slot_cnt == c_sw'(p_slot_cycles - 1)) begin
         r_slot_cnt <= '0;
         r_slot_dom <= ~r_slot_dom;
      end else begin
         r_slot_cnt <= r_slot_cnt + c_sw'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            r_head[d] <= '0;
            r_tail[d] <= '0;
            r_cnt[d]  <= '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (w_enq_d[d])
               r_tail[d] <= r_tail[d] + c_pw'(1);
            if (w_deq_d[d])
               r_head[d] <= r_head[d] + c_pw'(1);
            case ({w_enq_d[d], w_deq_d[d]})
               2'b10:   r_cnt[d] <= r_cnt[d] + c_cw'(1);
               2'b01:   r_cnt[d] <= r_cnt[d] - c_cw'(1);
               default: r_cnt[d] <= r_cnt[d];
            endcase
         end
      end
   end

   // Storage is not reset; counts alone define which entries are live
   always_ff @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (w_enq_d[d])
            r_mem[d][r_tail[d]] <= in_msg;
      end
   end

   a_no_x : assert property (@(posedge clk) disable iff (!reset)
      !$isunknown({out_val, in_rdy}));

endmodule
